// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default depth and Gray/binary conversion helpers,
// used by both the write-side and read-side pointer handlers.
package fifo_pkg;

    localparam int FIFO_PTR_WIDTH = 4;
    localparam int FIFO_DEPTH     = 2 ** FIFO_PTR_WIDTH;

    // Operate on a 32-bit container; callers zero-extend and truncate to their pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ff_sync.sv
// Multi-flop synchronizer for a Gray-coded bus crossing into the i_clk domain.
// Only one bit changes per source update, so per-bit resolution is safe.
module ff_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_d [STAGES];

    always_comb begin
        sync_d[0] = i_d;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i - 1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign o_q = sync_q[STAGES - 1];

endmodule

// File: rtl/wr_ptr_handler.sv
// Write-domain pointer and flag logic of the async FIFO: accepts writes, drives the memory
// address/strobe, exports the Gray write pointer and derives full/almost-full/level/overflow.
module wr_ptr_handler
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH   = FIFO_PTR_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = (2 ** PTR_WIDTH) - 2
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_en,
    input  logic [PTR_WIDTH:0]   i_g_rd_ptr,
    output logic [PTR_WIDTH-1:0] o_b_wr_ptr,
    output logic                 o_mem_wr,
    output logic [PTR_WIDTH:0]   o_g_wr_ptr,
    output logic                 o_full,
    output logic                 o_almost_full,
    output logic [PTR_WIDTH:0]   o_level,
    output logic                 o_overflow
);

    localparam int PW1 = PTR_WIDTH + 1;

    logic [PTR_WIDTH:0] b_wr_q, b_wr_d;
    logic [PTR_WIDTH:0] g_wr_q, g_wr_d;
    logic [PTR_WIDTH:0] level_q, level_d;
    logic [PTR_WIDTH:0] g_rd_s;
    logic [PTR_WIDTH:0] rd_bin;
    logic               full_q, full_d;
    logic               af_q, af_d;
    logic               ovf_q, ovf_d;
    logic               accept;

    ff_sync #(
        .WIDTH  (PW1),
        .STAGES (SYNC_STAGES)
    ) u_rd_sync (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_d    (i_g_rd_ptr),
        .o_q    (g_rd_s)
    );

    always_comb begin
        // Reset gates the strobe so no memory write escapes while pointers are being cleared.
        accept  = i_rstn & i_en & ~full_q;
        b_wr_d  = b_wr_q + PW1'(accept);
        g_wr_d  = PW1'(bin2gray(32'(b_wr_d)));
        rd_bin  = PW1'(gray2bin(32'(g_rd_s)));
        // Full when the write pointer has lapped the read pointer by exactly one depth.
        full_d  = (g_wr_d == {~g_rd_s[PTR_WIDTH:PTR_WIDTH-1], g_rd_s[PTR_WIDTH-2:0]});
        level_d = b_wr_d - rd_bin;
        af_d    = ({{(32 - PW1){1'b0}}, level_d} >= 32'(AF_THRESH));
        ovf_d   = ovf_q | (i_en & full_q);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            b_wr_q  <= '0;
            g_wr_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            b_wr_q  <= b_wr_d;
            g_wr_q  <= g_wr_d;
            level_q <= level_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_b_wr_ptr    = b_wr_q[PTR_WIDTH-1:0];
    assign o_mem_wr      = accept;
    assign o_g_wr_ptr    = g_wr_q;
    assign o_full        = full_q;
    assign o_almost_full = af_q;
    assign o_level       = level_q;
    assign o_overflow    = ovf_q;

endmodule

// File: tb/tb_wr_ptr_handler.sv
// Directed bench for wr_ptr_handler: a driver queues the expected post-edge outputs for each
// step, and a monitor pops and compares them at the following falling edge.
module tb_wr_ptr_handler;

    typedef struct packed {
        logic [7:0] tag;
        logic [3:0] b_wr;
        logic [4:0] g_wr;
        logic       full;
        logic       af;
        logic [4:0] level;
        logic       ovf;
        logic       mem_wr;
    } exp_t;

    logic       clk;
    logic       i_rstn;
    logic       i_en;
    logic [4:0] i_g_rd_ptr;
    logic [3:0] o_b_wr_ptr;
    logic       o_mem_wr;
    logic [4:0] o_g_wr_ptr;
    logic       o_full;
    logic       o_almost_full;
    logic [4:0] o_level;
    logic       o_overflow;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;

    wr_ptr_handler #(
        .PTR_WIDTH   (4),
        .SYNC_STAGES (2),
        .AF_THRESH   (14)
    ) dut (
        .i_clk         (clk),
        .i_rstn        (i_rstn),
        .i_en          (i_en),
        .i_g_rd_ptr    (i_g_rd_ptr),
        .o_b_wr_ptr    (o_b_wr_ptr),
        .o_mem_wr      (o_mem_wr),
        .o_g_wr_ptr    (o_g_wr_ptr),
        .o_full        (o_full),
        .o_almost_full (o_almost_full),
        .o_level       (o_level),
        .o_overflow    (o_overflow)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [4:0] gray5(input int k);
        logic [4:0] b;
        b = 5'(k);
        return b ^ (b >> 1);
    endfunction

    function automatic exp_t mk(input int tag, input int b, input logic [4:0] g, input logic full,
                                input logic af, input int level, input logic ovf, input logic mem);
        exp_t e;
        e.tag    = 8'(tag);
        e.b_wr   = 4'(b);
        e.g_wr   = g;
        e.full   = full;
        e.af     = af;
        e.level  = 5'(level);
        e.ovf    = ovf;
        e.mem_wr = mem;
        return e;
    endfunction

    // Driver: apply one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic rstn, input logic en, input logic [4:0] rd, input exp_t e);
        @(negedge clk);
        #1;
        i_rstn     = rstn;
        i_en       = en;
        i_g_rd_ptr = rd;
        step_no++;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int sno, input int ptag,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s phase=%0d step=%0d actual=%0h required=%0h", name, ptag, sno, act, req);
        end
    endtask

    // Scoreboard monitor
    int mon_step = 0;
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            mon_step++;
            chk("b_wr_ptr",    mon_step, int'(e.tag), 32'(o_b_wr_ptr),    32'(e.b_wr));
            chk("g_wr_ptr",    mon_step, int'(e.tag), 32'(o_g_wr_ptr),    32'(e.g_wr));
            chk("full",        mon_step, int'(e.tag), 32'(o_full),        32'(e.full));
            chk("almost_full", mon_step, int'(e.tag), 32'(o_almost_full), 32'(e.af));
            chk("level",       mon_step, int'(e.tag), 32'(o_level),       32'(e.level));
            chk("overflow",    mon_step, int'(e.tag), 32'(o_overflow),    32'(e.ovf));
            chk("mem_wr",      mon_step, int'(e.tag), 32'(o_mem_wr),      32'(e.mem_wr));
        end
    end

    initial begin
        int rdb;
        i_rstn     = 1'b0;
        i_en       = 1'b1;
        i_g_rd_ptr = '0;

        // 1: reset held with a write request, then released
        step(1'b0, 1'b1, 5'd0, mk(1, 0, 5'd0, 0, 0, 0, 0, 0));
        step(1'b0, 1'b1, 5'd0, mk(1, 0, 5'd0, 0, 0, 0, 0, 0));
        step(1'b1, 1'b0, 5'd0, mk(1, 0, 5'd0, 0, 0, 0, 0, 0));

        // 2: fill 16 slots with the read pointer parked at 0
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 1'b1, 5'd0, mk(2, k % 16, gray5(k), k == 16, k >= 14, k, 0, k != 16));
        end

        // 3: keep requesting while full
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 5'd0, mk(3, 0, 5'b11000, 1, 1, 16, 1, 0));
        end

        // 4: one read lands; full clears three edges later and one more write fits
        step(1'b1, 1'b1, 5'b00001, mk(4, 0, 5'b11000, 1, 1, 16, 1, 0));
        step(1'b1, 1'b1, 5'b00001, mk(4, 0, 5'b11000, 1, 1, 16, 1, 0));
        step(1'b1, 1'b1, 5'b00001, mk(4, 0, 5'b11000, 0, 1, 15, 1, 1));
        step(1'b1, 1'b1, 5'b00001, mk(4, 1, 5'b11001, 1, 1, 16, 1, 0));
        step(1'b1, 1'b0, 5'b00001, mk(4, 1, 5'b11001, 1, 1, 16, 1, 0));

        // 5: mid-operation reset clears overflow, then stream 40 writes with a lagging reader
        step(1'b0, 1'b1, 5'd0, mk(5, 0, 5'd0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 40; k++) begin
            rdb = (k >= 5) ? k - 5 : 0;
            step(1'b1, 1'b1, gray5(rdb), mk(5, k % 16, gray5(k % 32), 0, 0, (k < 7) ? k : 7, 0, 1));
        end

        // 6: reset, 9 writes, reset again, refill from address 0
        step(1'b0, 1'b0, 5'd0, mk(6, 0, 5'd0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 9; k++) begin
            step(1'b1, 1'b1, 5'd0, mk(6, k, gray5(k), 0, 0, k, 0, 1));
        end
        step(1'b0, 1'b1, 5'd0, mk(6, 0, 5'd0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, 1'b1, 5'd0, mk(6, k, gray5(k), 0, 0, k, 0, 1));
        end

        for (int n = 0; n < 10 && exp_q.size() > 0; n++) begin
            @(negedge clk);
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
